control_unit: RTL
=================

Name: control_unit

Overview:
- Instruction sequencer for the 16-bit processor.
- Fetches words from the synchronous instruction ROM, holds them in an instruction register (IR), and runs a Moore FSM.
- The FSM drives the datapath controls: RAM address/write enable, register-file read/write addresses and enables, write-back mux select and ALU select.
- It sits directly upstream of the RAM + register-file datapath and feeds every one of its control inputs.

Parameters:
- PC_W, 7, program-counter / ROM address width.
- START_ADDR, 0, PC value loaded on reset.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Instr  in  16  instruction ROM read data; valid one cycle after PC_Addr is presented.
- PC_Addr  out  PC_W  instruction ROM address.
- D_Addr  out  8  data RAM address.
- D_W_En  out  1  data RAM write enable.
- RF_s  out  1  register-file write-data mux select; 1 = RAM q, 0 = ALU.
- RF_W_Addr  out  4  register-file write address.
- RF_W_En  out  1  register-file write enable.
- RF_Ra_Addr  out  4  register-file A-side read address.
- RF_Rb_Addr  out  4  register-file B-side read address.
- ALU_s0  out  3  ALU op: 000 pass/zero, 001 add, 010 sub.
- Halted  out  1  high while in HALT.
- State  out  4  current FSM state encoding, for debug.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low (ResetN).
  - ResetN low forces state=INIT, PC=START_ADDR, IR=0, and all enables, RF_s, ALU_s0 and Halted to 0.
  - Applies at any point, including mid-LOAD or mid-STORE.
  - In-flight writes are abandoned; no partial register write occurs.
- Opcodes (IR[15:12]):
  - 0000 NOOP.
  - 0001 STORE: RAM[IR[11:4]] <= RF[IR[3:0]].
  - 0010 LOAD: RF[IR[3:0]] <= RAM[IR[11:4]].
  - 0011 ADD: RF[IR[3:0]] <= RF[IR[11:8]] + RF[IR[7:4]].
  - 0100 SUB: same fields as ADD, subtract.
  - 0101 HALT.
  - Any other opcode executes as NOOP.
- States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- Transitions:
  - INIT -> FETCH.
  - FETCH -> DECODE.
  - DECODE -> execute state selected by Instr[15:12], read combinationally in DECODE.
  - LOAD_A -> LOAD_B.
  - NOOP, LOAD_B, STORE, ADD, SUB -> FETCH.
  - HALT -> HALT until reset.
- Fetch and decode timing:
  - PC_Addr = PC in every state.
  - At the DECODE clock edge: IR <= Instr and PC <= PC+1. The PC wraps modulo 2^PC_W (127 -> 0).
- Outputs are a combinational decode of registered state and IR. Defaults are all 0.
  - STORE: D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_W_En=1 for exactly one cycle.
  - LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_En=0. This cycle covers the RAM's 1-cycle read latency.
  - LOAD_B: D_Addr held, RF_s=1, RF_W_Addr=IR[3:0], RF_W_En=1.
  - ADD/SUB: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_s=0, RF_W_En=1, ALU_s0=001 (ADD) or 010 (SUB).
  - HALT: Halted=1, all enables 0, PC frozen.
- Cycle counts per instruction: NOOP, STORE, ADD and SUB take 3 cycles; LOAD takes 4.
- Exactly one of D_W_En / RF_W_En is high in any cycle, or neither.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined:
  - Adds input port Step (1 bit).
  - FETCH holds, with PC and IR unchanged, until Step is sampled high; then it proceeds to DECODE.
  - Step held high continuously gives full-speed execution.
- When undefined: no Step port, and FETCH always advances after one cycle.

Decomposition:
- Package cpu_pkg:
  - state_t enum (4-bit, INIT=0 … HALT=9).
  - Opcode localparams OP_NOOP … OP_HALT.
  - ALU select localparams ALU_PASS/ALU_ADD/ALU_SUB.
  - Field-slice helper functions.
- Sub-module program_counter: PC register with synchronous load-enable (Inc), async clear to START_ADDR and wrap-around.
- FSM and output decode stay in control_unit.

Test Plan:
- Reset, then release:
  - During reset: State=INIT, PC_Addr=0, all enables 0.
  - First rising edge after release -> FETCH.
  - Next edge -> DECODE.
- ROM[0]=16'h21B3 (LOAD):
  - Sequence FETCH, DECODE, LOAD_A, LOAD_B.
  - In LOAD_A: D_Addr=8'h1B, RF_s=1, RF_W_En=0.
  - In LOAD_B: RF_W_En=1, RF_W_Addr=3.
  - PC_Addr=1 afterwards.
- ROM[1]=16'h3125 (ADD): in ADD state, RF_Ra_Addr=1, RF_Rb_Addr=2, RF_W_Addr=5, ALU_s0=001, RF_W_En=1 for one cycle.
- ROM[2]=16'h1406 (STORE): D_Addr=8'h40, RF_Ra_Addr=6, D_W_En=1 for one cycle, RF_W_En=0 throughout.
- ROM[3]=16'hF000, then ROM[4]=16'h5000:
  - Opcode F behaves as NOOP, with no enables asserted.
  - HALT gives Halted=1, State stays HALT for 50 cycles, PC_Addr stays 5.
- Extra checks:
  - 128 NOOPs: PC_Addr wraps 127 -> 0.
  - ResetN pulsed low during LOAD_A: immediate INIT, RF_W_En never asserted, PC_Addr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit processor control path: FSM states, opcodes,
// ALU selects and instruction field slices.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    function automatic logic [3:0] op_of(input logic [15:0] ir);
        return ir[15:12];
    endfunction

    // RAM address field of LOAD/STORE
    function automatic logic [7:0] mem_addr_of(input logic [15:0] ir);
        return ir[11:4];
    endfunction

    function automatic logic [3:0] ra_of(input logic [15:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [3:0] rb_of(input logic [15:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [3:0] rd_of(input logic [15:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: increments by one when inc is high, wraps modulo 2^PC_W,
// asynchronously cleared to START_ADDR. Zero-latency output of the register.
module program_counter
    import cpu_pkg::*;
#(
    parameter int          PC_W       = 7,
    parameter int unsigned START_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_W'(START_ADDR);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetches from a 1-cycle-latency ROM into IR and drives
// the RAM/register-file datapath from a Moore FSM. SINGLE_STEP_EN adds a Step gate on FETCH.
module control_unit
    import cpu_pkg::*;
#(
    parameter int          PC_W       = 7,
    parameter int unsigned START_ADDR = 0
) (
    input  logic            Clock,
    input  logic            ResetN,
`ifdef SINGLE_STEP_EN
    input  logic            Step,
`endif
    input  logic [15:0]     Instr,
    output logic [PC_W-1:0] PC_Addr,
    output logic [7:0]      D_Addr,
    output logic            D_W_En,
    output logic            RF_s,
    output logic [3:0]      RF_W_Addr,
    output logic            RF_W_En,
    output logic [3:0]      RF_Ra_Addr,
    output logic [3:0]      RF_Rb_Addr,
    output logic [2:0]      ALU_s0,
    output logic            Halted,
    output logic [3:0]      State
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ir_q;
    logic [15:0] ir_d;
    logic        pc_inc;

    program_counter #(
        .PC_W       (PC_W),
        .START_ADDR (START_ADDR)
    ) u_pc (
        .clk   (Clock),
        .rst_n (ResetN),
        .inc   (pc_inc),
        .pc    (PC_Addr)
    );

    // The ROM word for the current PC is only valid in DECODE, so IR capture
    // and the PC increment both happen on the edge leaving DECODE.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_inc  = 1'b0;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
`ifdef SINGLE_STEP_EN
                if (Step) begin
                    state_d = S_DECODE;
                end
`else
                state_d = S_DECODE;
`endif
            end
            S_DECODE: begin
                ir_d   = Instr;
                pc_inc = 1'b1;
                case (op_of(Instr))
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_INIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        D_Addr     = 8'h00;
        D_W_En     = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = 4'h0;
        RF_W_En    = 1'b0;
        RF_Ra_Addr = 4'h0;
        RF_Rb_Addr = 4'h0;
        ALU_s0     = ALU_PASS;
        Halted     = 1'b0;
        case (state_q)
            S_STORE: begin
                D_Addr     = mem_addr_of(ir_q);
                RF_Ra_Addr = rd_of(ir_q);
                D_W_En     = 1'b1;
            end
            // RAM read latency: address presented, write-back waits a cycle
            S_LOAD_A: begin
                D_Addr = mem_addr_of(ir_q);
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_Addr    = mem_addr_of(ir_q);
                RF_s      = 1'b1;
                RF_W_Addr = rd_of(ir_q);
                RF_W_En   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = ra_of(ir_q);
                RF_Rb_Addr = rb_of(ir_q);
                RF_W_Addr  = rd_of(ir_q);
                RF_W_En    = 1'b1;
                ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

    assign State = state_q;

endmodule
